// File: rtl/mi_nios_led_pwm_if.sv
// Avalon-MM slave bus bundle for the LED PWM PIO.
interface mi_nios_led_pwm_if;
    logic [5:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/mi_nios_led_pwm.sv
// LED PIO with atomic set/clear and per-channel PWM on a shared, prescaled timebase.
// Active duties are shadowed and reload only at frame wrap so duty changes never glitch.
module mi_nios_led_pwm_lane #(
    parameter int   PWM_BITS = 8,
    parameter logic RST_BIT  = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                wrap,
    input  logic                duty_we,
    input  logic [PWM_BITS-1:0] duty_wd,
    input  logic [PWM_BITS-1:0] cnt,
    input  logic                data_bit,
    input  logic                mode_bit,
    output logic [PWM_BITS-1:0] pending,
    output logic                out_bit
);
    logic [PWM_BITS-1:0] active;
    logic                on;

    // all-ones duty means fully on; the compare alone would drop one tick
    assign on = (&active) | (cnt < active);

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
            active  <= '0;
            out_bit <= RST_BIT;
        end else begin
            if (duty_we) pending <= duty_wd;
            if (!en || wrap) active <= pending;
            out_bit <= mode_bit ? (en & data_bit & on) : data_bit;
        end
    end
endmodule

module mi_nios_led_pwm #(
    parameter int               WIDTH         = 8,
    parameter int               PWM_BITS      = 8,
    parameter int               PRESCALE_BITS = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
    input  logic              clk,
    input  logic              reset,
    mi_nios_led_pwm_if.slave  bus,
    output logic [WIDTH-1:0]  out_port
);
    logic                               wr, rd, tick, wrap;
    logic [WIDTH-1:0]                   data, mode;
    logic [PRESCALE_BITS-1:0]           prescale, pc;
    logic                               en, sticky;
    logic [PWM_BITS-1:0]                cnt;
    logic [WIDTH-1:0][PWM_BITS-1:0]     pending;
    logic [31:0]                        rdata;
    logic                               unused_wd;

    assign wr        = bus.chipselect & ~bus.write_n;
    assign rd        = bus.chipselect & bus.write_n;
    assign tick      = en & (pc == '0);
    assign wrap      = tick & (&cnt);
    assign unused_wd = ^bus.writedata;

    always_comb begin
        rdata = '0;
        case (bus.address)
            6'd0: rdata[WIDTH-1:0]         = data;
            6'd3: rdata[WIDTH-1:0]         = mode;
            6'd4: rdata[PRESCALE_BITS-1:0] = prescale;
            6'd5: rdata[1:0]               = {sticky, en};
            6'd6: rdata[PWM_BITS-1:0]      = cnt;
            default: begin
                for (int i = 0; i < WIDTH; i++)
                    if (bus.address == 6'(8 + i)) rdata[PWM_BITS-1:0] = pending[i];
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data         <= RESET_VALUE;
            mode         <= '0;
            prescale     <= '0;
            en           <= 1'b0;
            sticky       <= 1'b0;
            pc           <= '0;
            cnt          <= '0;
            bus.readdata <= '0;
        end else begin
            if (wr) begin
                case (bus.address)
                    6'd0: data     <= bus.writedata[WIDTH-1:0];
                    6'd1: data     <= data | bus.writedata[WIDTH-1:0];
                    6'd2: data     <= data & ~bus.writedata[WIDTH-1:0];
                    6'd3: mode     <= bus.writedata[WIDTH-1:0];
                    6'd4: prescale <= bus.writedata[PRESCALE_BITS-1:0];
                    6'd5: en       <= bus.writedata[0];
                    default: ;
                endcase
            end
            // a wrap on the same edge as a write-1-to-clear keeps the flag set
            if (wrap)
                sticky <= 1'b1;
            else if (wr && bus.address == 6'd5 && bus.writedata[1])
                sticky <= 1'b0;
            if (!en) begin
                pc  <= '0;
                cnt <= '0;
            end else begin
                if (wr && bus.address == 6'd4) pc <= bus.writedata[PRESCALE_BITS-1:0];
                else if (tick)                 pc <= prescale;
                else                           pc <= pc - 1'b1;
                if (tick) cnt <= cnt + 1'b1;
            end
            bus.readdata <= rd ? rdata : '0;
        end
    end

    for (genvar n = 0; n < WIDTH; n++) begin : g_lane
        mi_nios_led_pwm_lane #(
            .PWM_BITS (PWM_BITS),
            .RST_BIT  (RESET_VALUE[n])
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .en       (en),
            .wrap     (wrap),
            .duty_we  (wr && bus.address == 6'(8 + n)),
            .duty_wd  (bus.writedata[PWM_BITS-1:0]),
            .cnt      (cnt),
            .data_bit (data[n]),
            .mode_bit (mode[n]),
            .pending  (pending[n]),
            .out_bit  (out_port[n])
        );
    end
endmodule

// File: tb/tb_mi_nios_led_pwm.sv
// Directed plus randomized bench for mi_nios_led_pwm against a behavioural register/PWM model.
module tb_mi_nios_led_pwm;
    localparam int W = 8, PB = 8, PSB = 16;
    localparam int MAXD = (1 << PB) - 1;
    localparam logic [W-1:0] RV = 8'h5A;

    logic clk = 1'b0, reset = 1'b1;
    logic [W-1:0] out_port;
    always #5 clk = ~clk;

    mi_nios_led_pwm_if bus ();
    mi_nios_led_pwm #(.WIDTH(W), .PWM_BITS(PB), .PRESCALE_BITS(PSB), .RESET_VALUE(RV)) dut (
        .clk(clk), .reset(reset), .bus(bus), .out_port(out_port));

    int tests = 0, fails = 0;

    logic [W-1:0]   m_data, m_mode, m_out;
    logic [PSB-1:0] m_pre, m_pc;
    logic           m_en, m_sticky;
    int             m_cnt;
    int             m_pend[W], m_act[W];
    logic [31:0]    m_rd;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mread(logic [5:0] a);
        case (a)
            6'd0: return 32'(m_data);
            6'd3: return 32'(m_mode);
            6'd4: return 32'(m_pre);
            6'd5: return {30'd0, m_sticky, m_en};
            6'd6: return 32'(m_cnt);
            default: return (a >= 8 && a < 8 + W) ? 32'(m_pend[a-8]) : 32'd0;
        endcase
    endfunction

    // One clock edge of the register map, using pre-edge state for everything sampled.
    task automatic model_edge(logic cs, logic wn, logic [5:0] a, logic [31:0] wd, logic rst);
        logic wr, tick, wrap;
        if (rst) begin
            m_data = RV; m_out = RV; m_rd = '0; m_mode = '0; m_pre = '0;
            m_en = 1'b0; m_sticky = 1'b0; m_pc = '0; m_cnt = 0;
            for (int n = 0; n < W; n++) begin m_pend[n] = 0; m_act[n] = 0; end
            return;
        end
        wr   = cs & ~wn;
        tick = m_en && (m_pc == 0);
        wrap = tick && (m_cnt == MAXD);
        m_rd = (cs && wn) ? mread(a) : 32'd0;
        for (int n = 0; n < W; n++) begin
            bit on;
            on = (m_act[n] == MAXD) || (m_cnt < m_act[n]);
            m_out[n] = m_mode[n] ? (m_en && m_data[n] && on) : m_data[n];
        end
        for (int n = 0; n < W; n++) if (!m_en || wrap) m_act[n] = m_pend[n];
        if (wrap) m_sticky = 1'b1;
        else if (wr && a == 6'd5 && wd[1]) m_sticky = 1'b0;
        if (!m_en) begin
            m_pc = '0; m_cnt = 0;
        end else begin
            if (wr && a == 6'd4) m_pc = wd[PSB-1:0];
            else if (tick)       m_pc = m_pre;
            else                 m_pc = m_pc - 1'b1;
            if (tick) m_cnt = (m_cnt + 1) % (MAXD + 1);
        end
        if (wr) begin
            case (a)
                6'd0: m_data = wd[W-1:0];
                6'd1: m_data = m_data | wd[W-1:0];
                6'd2: m_data = m_data & ~wd[W-1:0];
                6'd3: m_mode = wd[W-1:0];
                6'd4: m_pre  = wd[PSB-1:0];
                6'd5: m_en   = wd[0];
                default: if (a >= 8 && a < 8 + W) m_pend[a-8] = int'(wd[PB-1:0]);
            endcase
        end
    endtask

    task automatic step(logic cs, logic wn, logic [5:0] a, logic [31:0] wd, logic rst);
        @(negedge clk);
        bus.chipselect = cs; bus.write_n = wn; bus.address = a; bus.writedata = wd; reset = rst;
        @(posedge clk);
        model_edge(cs, wn, a, wd, rst);
        #1;
        chk("out_port", 32'(out_port), 32'(m_out));
        chk("readdata", bus.readdata, m_rd);
    endtask

    task automatic wr(logic [5:0] a, logic [31:0] d); step(1'b1, 1'b0, a, d, 1'b0); endtask
    task automatic rd(logic [5:0] a);                 step(1'b1, 1'b1, a, 32'd0, 1'b0); endtask
    task automatic idle();                            step(1'b0, 1'b1, 6'd0, 32'd0, 1'b0); endtask

    task automatic count_hi(int cycles, output int hi);
        hi = 0;
        repeat (cycles) begin idle(); hi += int'(out_port[0]); end
    endtask

    initial begin
        int hi, c1, c2, k;
        bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.address = '0; bus.writedata = '0;

        step(1'b0, 1'b1, 6'd0, 32'd0, 1'b1);
        step(1'b0, 1'b1, 6'd0, 32'd0, 1'b1);
        rd(6'd0); chk("rst_data_rd", bus.readdata, 32'(RV)); chk("rst_out", 32'(out_port), 32'(RV));
        rd(6'd3); chk("rst_mode", bus.readdata, 32'd0);
        rd(6'd5); chk("rst_ctrl", bus.readdata, 32'd0);
        rd(6'd6); chk("rst_pwmcnt", bus.readdata, 32'd0);

        wr(6'd0, 32'hA5); idle(); chk("data_a5", 32'(out_port), 32'hA5);
        wr(6'd1, 32'h0F); idle(); chk("outset", 32'(out_port), 32'hAF);
        wr(6'd2, 32'h81); idle(); chk("outclr", 32'(out_port), 32'h2E);
        rd(6'd1); chk("outset_rd0", bus.readdata, 32'd0);
        wr(6'd1, 32'h0); wr(6'd2, 32'hFFFF_FF00); idle(); chk("set_clr_noop", 32'(out_port), 32'h2E);

        wr(6'd3, 32'h01); wr(6'd8, 32'd64); wr(6'd4, 32'd0); wr(6'd0, 32'h01); wr(6'd5, 32'd1);
        repeat (4) idle();
        count_hi(256, hi); chk("pwm_hi64", hi, 64);

        wr(6'd5, 32'h3); rd(6'd5); chk("sticky_clr", bus.readdata, 32'h1);
        for (k = 0; k < 600 && m_cnt != 100; k++) idle();
        rd(6'd6); chk("reach_cnt100", bus.readdata, 32'd100);
        wr(6'd8, 32'd200);
        for (k = 0; k < 600 && m_cnt != 1; k++) idle();
        rd(6'd5); chk("sticky_set", bus.readdata, 32'h3);
        count_hi(256, hi); chk("pwm_hi200", hi, 200);

        wr(6'd4, 32'd3);
        rd(6'd6); c1 = int'(bus.readdata);
        repeat (3) idle();
        rd(6'd6); c2 = int'(bus.readdata);
        chk("presc_step", 32'((c2 - c1) & MAXD), 32'd1);
        wr(6'd8, 32'hFF); repeat (1100) idle();
        count_hi(1024, hi); chk("duty_ff_on", hi, 1024);
        wr(6'd8, 32'd0); repeat (1100) idle();
        count_hi(1024, hi); chk("duty_0_off", hi, 0);

        wr(6'd4, 32'd0);
        repeat (800) begin
            logic [5:0]  a;
            logic [31:0] d;
            a = 6'($urandom_range(0, 19));
            d = $urandom;
            if (a == 6'd4) d = d & 32'h3;
            if (a == 6'd5 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a, d, $urandom_range(0, 199) == 0);
        end

        wr(6'd3, 32'hFF); wr(6'd4, 32'd0); wr(6'd5, 32'd1); wr(6'd0, 32'hFF);
        repeat (50) idle();
        step(1'b1, 1'b0, 6'd0, 32'h0F, 1'b1);
        chk("midrst_out", 32'(out_port), 32'(RV));
        rd(6'd6); chk("midrst_cnt", bus.readdata, 32'd0);
        rd(6'd5); chk("midrst_ctrl", bus.readdata, 32'd0);
        rd(6'd0); chk("midrst_wr_drop", bus.readdata, 32'(RV));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mi_nios_led_pwm.md
Name: mi_nios_led_pwm

Overview:
- Parametrised successor to the single-register 8-bit LED PIO. It is an Avalon-MM slave on the Nios II data bus driving WIDTH output pins.
- Adds atomic set/clear writes and a per-channel static/PWM mode select.
- Each channel has its own PWM duty. The PWM timebase is shared, with a programmable prescaler, and duty updates are glitch-free at frame boundaries.
- Outputs and readdata are registered.

Parameters:
- WIDTH, 8, number of output channels (1..32).
- PWM_BITS, 8, PWM counter/duty width (2..16); frame = 2^PWM_BITS ticks.
- PRESCALE_BITS, 16, prescaler reload width (1..32).
- RESET_VALUE, 0, WIDTH-bit reset value of DATA and out_port.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  6  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; write = chipselect & ~write_n.
- writedata  in  32  write data.
- readdata  out  32  read data, latency 1.
- out_port  out  WIDTH  LED drive, registered.

Behaviour:
- Register map (word addresses):
  - 0 DATA (rw, WIDTH bits).
  - 1 OUTSET (wo, DATA |= wd).
  - 2 OUTCLR (wo, DATA &= ~wd).
  - 3 MODE (rw, WIDTH bits, 1 = PWM).
  - 4 PRESCALE (rw, PRESCALE_BITS).
  - 5 CTRL (rw: bit0 EN; bit1 FRAME_STICKY, read-only, write 1 to clear).
  - 6 PWMCNT (ro).
  - 8..8+WIDTH-1 DUTY[n] (rw, PWM_BITS; reads return the pending value).
- Unused/unmapped addresses: writes ignored, reads 0. Unused upper bits read 0. Write-only registers read 0.
- Reset (reset=1 at an edge): DATA=RESET_VALUE, out_port=RESET_VALUE, readdata=0, and all of the following are 0: MODE, PRESCALE, EN, FRAME_STICKY, prescaler counter, PWM counter, all pending and active duties. Reset overrides a simultaneous write. Reset mid-frame aborts the frame.
- Write timing: write sampled at edge E updates the register at E. out_port reflects the change at edge E+1, a latency of 2 edges from the write.
- Read timing: readdata at edge E+1 holds the value of the register addressed at E, while chipselect=1 and write_n=1. Otherwise readdata is 0. No read side effects.
- Prescaler:
  - Runs only while EN=1. It is a down-counter; tick=1 when the count is 0, and the counter then reloads PRESCALE. Otherwise it decrements.
  - Writing PRESCALE loads the new value into the counter at the next edge.
  - EN=0 holds the prescaler and PWM counter at 0.
- PWM counter:
  - Increments by 1 on each tick and wraps 2^PWM_BITS-1 -> 0.
  - Frame period = (PRESCALE+1)*2^PWM_BITS clocks.
- Duty shadowing:
  - A DUTY write updates the pending register only.
  - All active duties load from pending when the counter wraps to 0 on a tick. The same edge sets FRAME_STICKY.
  - While EN=0, active duties follow pending every cycle.
  - If a DUTY write and a wrap occur at the same edge, the old pending value is loaded; the new value applies at the next wrap.
  - If a FRAME_STICKY clear and a set occur at the same edge, set wins.
- Output, per channel n:
  - MODE[n]=0: out[n]=DATA[n].
  - MODE[n]=1 and EN=0: out[n]=0.
  - MODE[n]=1 and EN=1: out[n] = DATA[n] & (active_duty[n]==all-ones ? 1 : pwm_cnt < active_duty[n]).
  - Duty 0 is always off; all-ones is always on. Otherwise the on-time is duty ticks per frame.
- OUTSET and OUTCLR with wd=0 are no-ops. Bits of wd above WIDTH are ignored.

Test Plan:
- Reset, then read DATA -> readdata=RESET_VALUE one cycle later. out_port=RESET_VALUE. Reads of MODE, CTRL and PWMCNT return 0.
- Write DATA=0xA5, then OUTSET 0x0F, then OUTCLR 0x81 -> out_port sequence 0xA5, 0xAF, 0x2E, each 2 edges after its write. A read of OUTSET returns 0.
- MODE=0x01, DUTY[0]=64, PRESCALE=0, EN=1, DATA[0]=1, PWM_BITS=8 -> out_port[0] is high 64 of every 256 clocks with period 256.
- Mid-frame (PWMCNT=100), write DUTY[0]=200 -> the current frame still ends high-time at count 64. The next frame is high for 200 counts, and FRAME_STICKY=1 at the wrap.
- PRESCALE=3 -> PWMCNT advances every 4 clocks, frame = 1024 clocks. DUTY=0xFF -> always high. DUTY=0 -> always low.
- Assert reset for 1 cycle mid-frame with EN=1 -> the next cycle has PWMCNT=0, EN=0, out_port=RESET_VALUE, and a write issued in the reset cycle is discarded.
